// File: rtl/keypad_pkg.sv
// Shared constants for the keypad scanner: key codes, scan FSM encoding
// and the row/column-to-code map used when a press is confirmed.
package keypad_pkg;

    localparam logic [3:0] KEY_STAR = 4'hE;
    localparam logic [3:0] KEY_HASH = 4'hF;

    localparam logic [1:0] SCAN     = 2'd0;
    localparam logic [1:0] DEBOUNCE = 2'd1;
    localparam logic [1:0] HOLD     = 2'd2;

    typedef logic [1:0] scan_state_t;

    // Row-major layout: 1 2 3 A / 4 5 6 B / 7 8 9 C / * 0 # D
    function automatic logic [3:0] key_lookup(input logic [1:0] row_idx,
                                              input logic [1:0] col_idx);
        logic [3:0] code;
        case ({row_idx, col_idx})
            4'h0:    code = 4'h1;
            4'h1:    code = 4'h2;
            4'h2:    code = 4'h3;
            4'h3:    code = 4'hA;
            4'h4:    code = 4'h4;
            4'h5:    code = 4'h5;
            4'h6:    code = 4'h6;
            4'h7:    code = 4'hB;
            4'h8:    code = 4'h7;
            4'h9:    code = 4'h8;
            4'hA:    code = 4'h9;
            4'hB:    code = 4'hC;
            4'hC:    code = KEY_STAR;
            4'hD:    code = 4'h0;
            4'hE:    code = KEY_HASH;
            default: code = 4'hD;
        endcase
        return code;
    endfunction

    function automatic logic [1:0] lowest_low_row(input logic [3:0] rows);
        logic [1:0] idx;
        if (!rows[0])      idx = 2'd0;
        else if (!rows[1]) idx = 2'd1;
        else if (!rows[2]) idx = 2'd2;
        else               idx = 2'd3;
        return idx;
    endfunction

    function automatic logic is_digit(input logic [3:0] code);
        return (code <= 4'd9);
    endfunction

endpackage

// File: rtl/keypad_entry_reg.sv
// Two-digit BCD entry register: shifts in digit keys, clears on '*',
// commits on '#' with a one-cycle entry_valid pulse, then clears.
module keypad_entry_reg
    import keypad_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       key_valid,
    input  logic [3:0] key_code,
    output logic [7:0] entry_bcd,
    output logic       entry_valid
);

    logic [7:0] bcd_q, bcd_d;
    logic [1:0] count_q, count_d;
    logic       valid_q, valid_d;

    always_comb begin
        bcd_d   = bcd_q;
        count_d = count_q;
        valid_d = 1'b0;
        // The cycle after a commit clears the value the consumer just loaded.
        if (valid_q) begin
            bcd_d   = 8'h00;
            count_d = 2'd0;
        end else if (key_valid) begin
            if (is_digit(key_code)) begin
                bcd_d   = {bcd_q[3:0], key_code};
                count_d = (count_q == 2'd2) ? 2'd2 : count_q + 2'd1;
            end else if (key_code == KEY_STAR) begin
                bcd_d   = 8'h00;
                count_d = 2'd0;
            end else if (key_code == KEY_HASH && count_q != 2'd0) begin
                valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            bcd_q   <= 8'h00;
            count_q <= 2'd0;
            valid_q <= 1'b0;
        end else begin
            bcd_q   <= bcd_d;
            count_q <= count_d;
            valid_q <= valid_d;
        end
    end

    assign entry_bcd   = bcd_q;
    assign entry_valid = valid_q;

endmodule

// File: rtl/keypad_digit_entry.sv
// 4x4 keypad scanner with debounce and optional BCD entry register.
// Define KEYPAD_ENTRY_EN to include the entry register; otherwise entry outputs are tied off.
module keypad_digit_entry
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV       = 50000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic       key_valid,
    output logic [3:0] key_code,
    output logic [7:0] entry_bcd,
    output logic       entry_valid
);

    localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int CNT_W = (DEBOUNCE_SCANS > 1) ? $clog2(DEBOUNCE_SCANS + 1) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_SCANS - 1);

    scan_state_t      state_q, state_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       col_idx_q, col_idx_d;
    logic [1:0]       row_idx_q, row_idx_d;
    logic             key_valid_q, key_valid_d;
    logic [3:0]       key_code_q, key_code_d;
    logic [3:0]       row_meta_q, row_sync_q;
    logic             sample;

    // Rows come straight off the header pins, so bring them into clk first.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            row_meta_q <= 4'hF;
            row_sync_q <= 4'hF;
        end else begin
            row_meta_q <= row;
            row_sync_q <= row_meta_q;
        end
    end

    assign sample = (div_q == DIV_LAST);

    always_comb begin
        state_d     = state_q;
        div_d       = sample ? '0 : div_q + 1'b1;
        cnt_d       = cnt_q;
        col_idx_d   = col_idx_q;
        row_idx_d   = row_idx_q;
        key_valid_d = 1'b0;
        key_code_d  = key_code_q;
        if (sample) begin
            case (state_q)
                SCAN: begin
                    if (row_sync_q == 4'hF) begin
                        col_idx_d = col_idx_q + 2'd1;
                    end else begin
                        row_idx_d = lowest_low_row(row_sync_q);
                        if (DEBOUNCE_SCANS <= 1) begin
                            state_d     = HOLD;
                            cnt_d       = '0;
                            key_valid_d = 1'b1;
                            key_code_d  = key_lookup(lowest_low_row(row_sync_q), col_idx_q);
                        end else begin
                            state_d = DEBOUNCE;
                            cnt_d   = CNT_W'(1);
                        end
                    end
                end
                DEBOUNCE: begin
                    // Only the latched row is tracked; other rows in this column are ignored.
                    if (!row_sync_q[row_idx_q]) begin
                        if (cnt_q == CNT_LAST) begin
                            state_d     = HOLD;
                            cnt_d       = '0;
                            key_valid_d = 1'b1;
                            key_code_d  = key_lookup(row_idx_q, col_idx_q);
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end else begin
                        state_d   = SCAN;
                        cnt_d     = '0;
                        col_idx_d = col_idx_q + 2'd1;
                    end
                end
                HOLD: begin
                    if (row_sync_q == 4'hF) begin
                        if (cnt_q == CNT_LAST) begin
                            state_d   = SCAN;
                            cnt_d     = '0;
                            col_idx_d = col_idx_q + 2'd1;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end else begin
                        cnt_d = '0;
                    end
                end
                default: begin
                    state_d   = SCAN;
                    cnt_d     = '0;
                    col_idx_d = 2'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_q     <= SCAN;
            div_q       <= '0;
            cnt_q       <= '0;
            col_idx_q   <= 2'd0;
            row_idx_q   <= 2'd0;
            key_valid_q <= 1'b0;
            key_code_q  <= 4'h0;
        end else begin
            state_q     <= state_d;
            div_q       <= div_d;
            cnt_q       <= cnt_d;
            col_idx_q   <= col_idx_d;
            row_idx_q   <= row_idx_d;
            key_valid_q <= key_valid_d;
            key_code_q  <= key_code_d;
        end
    end

    assign col       = ~(4'b0001 << col_idx_q);
    assign key_valid = key_valid_q;
    assign key_code  = key_code_q;

`ifdef KEYPAD_ENTRY_EN
    keypad_entry_reg u_entry_reg (
        .clk         (clk),
        .rst_n       (rst_n),
        .key_valid   (key_valid_q),
        .key_code    (key_code_q),
        .entry_bcd   (entry_bcd),
        .entry_valid (entry_valid)
    );
`else
    assign entry_bcd   = 8'h00;
    assign entry_valid = 1'b0;
`endif

endmodule

// File: tb/tb_keypad_digit_entry.sv
// Scoreboard bench for keypad_digit_entry with a behavioural keypad matrix;
// entry expectations follow KEYPAD_ENTRY_EN.
module tb_keypad_digit_entry;

`ifdef KEYPAD_ENTRY_EN
    localparam bit ENTRY_EN = 1'b1;
`else
    localparam bit ENTRY_EN = 1'b0;
`endif

    logic       clk;
    logic       rst_n;
    logic [3:0] row;
    logic [3:0] col;
    logic       key_valid;
    logic [3:0] key_code;
    logic [7:0] entry_bcd;
    logic       entry_valid;

    logic [15:0] pressed;
    logic        useOverride;
    logic [3:0]  rowOverride;

    logic [3:0] keyQ[$];
    logic [7:0] entryQ[$];
    logic [7:0] entryModel;
    int         digitCount;
    bit         clearPending;

    int checkCount;
    int errorCount;

    localparam logic [3:0] CODE_TABLE [16] = '{
        4'h1, 4'h2, 4'h3, 4'hA,
        4'h4, 4'h5, 4'h6, 4'hB,
        4'h7, 4'h8, 4'h9, 4'hC,
        4'hE, 4'h0, 4'hF, 4'hD
    };

    keypad_digit_entry #(
        .SCAN_DIV       (4),
        .DEBOUNCE_SCANS (3)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .row         (row),
        .col         (col),
        .key_valid   (key_valid),
        .key_code    (key_code),
        .entry_bcd   (entry_bcd),
        .entry_valid (entry_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Keypad matrix: a pressed key pulls its row low while its column is driven low.
    always_comb begin
        row = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (pressed[r*4+c] && !col[c]) row[r] = 1'b0;
        if (useOverride) row = rowOverride;
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
        end
    endtask

    always @(negedge clk) begin
        if (key_valid) begin
            if (keyQ.size() == 0) checkOutput("unexpected_key_valid", 32'd1, 32'd0);
            else checkOutput("key_code", {28'd0, key_code}, {28'd0, keyQ.pop_front()});
        end
        if (entry_valid) begin
            if (entryQ.size() == 0) checkOutput("unexpected_entry_valid", 32'd1, 32'd0);
            else checkOutput("entry_bcd_commit", {24'd0, entry_bcd}, {24'd0, entryQ.pop_front()});
            clearPending = 1'b1;
        end else if (clearPending) begin
            checkOutput("entry_clear_after_commit", {24'd0, entry_bcd}, 32'd0);
            clearPending = 1'b0;
        end
    end

    task automatic updateEntryModel(input logic [3:0] code);
        if (!ENTRY_EN) return;
        if (code <= 4'd9) begin
            entryModel = {entryModel[3:0], code};
            if (digitCount < 2) digitCount++;
        end else if (code == 4'hE) begin
            entryModel = 8'h00;
            digitCount = 0;
        end else if (code == 4'hF && digitCount != 0) begin
            entryQ.push_back(entryModel);
            entryModel = 8'h00;
            digitCount = 0;
        end
    endtask

    task automatic waitKeyDrain(input int budget);
        int n = 0;
        while (keyQ.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (keyQ.size() != 0) begin
            checkOutput("key_valid_timeout", keyQ.size(), 32'd0);
            keyQ.delete();
        end
    endtask

    task automatic applyStimulus(input logic [15:0] mask, input logic [3:0] code);
        pressed = mask;
        keyQ.push_back(code);
        updateEntryModel(code);
        waitKeyDrain(300);
        repeat (60) @(negedge clk);
        pressed = 16'h0;
        repeat (40) @(negedge clk);
        if (entryQ.size() != 0) begin
            checkOutput("entry_valid_missing", entryQ.size(), 32'd0);
            entryQ.delete();
        end
    endtask

    task automatic pressKey(input int r, input int c);
        applyStimulus(16'(1) << (r*4+c), CODE_TABLE[r*4+c]);
    endtask

    task automatic waitForCol(input logic [3:0] target);
        int n = 0;
        while (col == target && n < 100) begin @(negedge clk); n++; end
        while (col != target && n < 200) begin @(negedge clk); n++; end
        if (col != target) checkOutput("col_wait_timeout", {28'd0, col}, {28'd0, target});
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        checkCount   = 0;
        errorCount   = 0;
        pressed      = 16'h0;
        useOverride  = 1'b0;
        rowOverride  = 4'hF;
        entryModel   = 8'h00;
        digitCount   = 0;
        clearPending = 1'b0;
        rst_n        = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("reset_col", {28'd0, col}, 32'hE);
        checkOutput("reset_key_valid", {31'd0, key_valid}, 32'd0);
        checkOutput("reset_key_code", {28'd0, key_code}, 32'd0);
        checkOutput("reset_entry_bcd", {24'd0, entry_bcd}, 32'd0);
        checkOutput("reset_entry_valid", {31'd0, entry_valid}, 32'd0);
        rst_n = 1'b0;

        // Key 5 held: single pulse, column held during HOLD.
        pressed = 16'(1) << 5;
        keyQ.push_back(4'h5);
        updateEntryModel(4'h5);
        waitKeyDrain(300);
        repeat (50) @(negedge clk);
        checkOutput("hold_col", {28'd0, col}, 32'hD);
        checkOutput("hold_key_code", {28'd0, key_code}, 32'h5);
        pressed = 16'h0;
        repeat (40) @(negedge clk);

        // One-sample glitch on row 0 in column 2 is rejected.
        waitForCol(4'b1011);
        useOverride = 1'b1;
        rowOverride = 4'b1110;
        repeat (4) @(negedge clk);
        checkOutput("glitch_col_held", {28'd0, col}, 32'hB);
        useOverride = 1'b0;
        repeat (4) @(negedge clk);
        checkOutput("glitch_col_advance", {28'd0, col}, 32'h7);
        repeat (20) @(negedge clk);

        pressKey(1, 0);
        pressKey(0, 1);
        pressKey(3, 2);

        pressKey(0, 0);
        pressKey(0, 1);
        pressKey(0, 2);
        pressKey(3, 2);

        pressKey(2, 0);
        pressKey(3, 0);
        pressKey(3, 2);
        checkOutput("entry_after_star_hash", {24'd0, entry_bcd}, {24'd0, entryModel});

        // Keys 2 and 8 together: lowest row wins.
        applyStimulus((16'(1) << 1) | (16'(1) << 9), 4'h2);

        // Reset during HOLD with key 9 held.
        pressed = 16'(1) << 10;
        keyQ.push_back(4'h9);
        updateEntryModel(4'h9);
        waitKeyDrain(300);
        repeat (10) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("rst_hold_col", {28'd0, col}, 32'hE);
        checkOutput("rst_hold_key_valid", {31'd0, key_valid}, 32'd0);
        checkOutput("rst_hold_key_code", {28'd0, key_code}, 32'd0);
        checkOutput("rst_hold_entry_bcd", {24'd0, entry_bcd}, 32'd0);
        checkOutput("rst_hold_entry_valid", {31'd0, entry_valid}, 32'd0);
        keyQ.delete();
        entryQ.delete();
        entryModel   = 8'h00;
        digitCount   = 0;
        clearPending = 1'b0;
        rst_n        = 1'b0;
        keyQ.push_back(4'h9);
        updateEntryModel(4'h9);
        waitKeyDrain(300);
        repeat (60) @(negedge clk);
        pressed = 16'h0;
        repeat (40) @(negedge clk);
        checkOutput("final_entry_bcd", {24'd0, entry_bcd}, {24'd0, entryModel});

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule

// File: doc/keypad_digit_entry.md
# keypad_digit_entry

- Scans a 4x4 matrix keypad, debounces presses, and emits one key code per press.
- Accumulates up to two decimal digits into a BCD entry value that the up/down counter loads as its preset.
- This is the input-side counterpart of the counter's BCD-to-seven-segment output path: it turns physical key contacts into BCD, where the display path turns BCD into segments.
- It sits between the keypad header and the counter's load/preset input.

## Interface
Parameters:
- SCAN_DIV, default 50000: clock cycles per column strobe; rows are sampled once per strobe.
- DEBOUNCE_SCANS, default 4: number of consecutive matching samples that confirm a press or a release.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous, active-high reset (despite the name); sampled on the rising edge of clk
- row  in  4  keypad rows; active-low, externally pulled up
- col  out  4  keypad columns; active-low, exactly one bit low at any time
- key_valid  out  1  one-cycle pulse per confirmed press
- key_code  out  4  code of the last confirmed key; held between pulses
- entry_bcd  out  8  {tens, units} BCD entry value
- entry_valid  out  1  one-cycle pulse; entry_bcd is valid in the same cycle

## Operation
- Key map, row-major from row 0 / column 0: 1 2 3 A / 4 5 6 B / 7 8 9 C / * 0 # D.
- Key codes: digits map to 0x0-0x9; A=0xA, B=0xB, C=0xC, D=0xD, *=0xE, #=0xF.
- Scan FSM states:
  - SCAN: drive column c low, count SCAN_DIV cycles, sample rows on the last cycle. All rows high: advance c (3 wraps to 0). Any row low: latch the lowest low row index, go to DEBOUNCE.
  - DEBOUNCE: column held. Each sample must equal the latched row pattern. DEBOUNCE_SCANS consecutive matches (the first match is the sample that entered DEBOUNCE) confirm the key; go to HOLD and pulse key_valid. Any mismatch returns to SCAN with the next column.
  - HOLD: column held. Wait for DEBOUNCE_SCANS consecutive all-high samples, then return to SCAN with the next column. A low sample restarts the release count.
- There is no autorepeat; a held key yields exactly one key_valid.
- Several rows low in one column: the lowest row wins, and that row alone is debounced.
- Entry register:
  - Digit key: entry_bcd <= {entry_bcd[3:0], digit}; digit count saturates at 2; the older digit is dropped.
  - '*': entry_bcd and digit count cleared.
  - '#' with count ≥ 1: entry_valid pulses with the current entry_bcd; entry_bcd and count clear on the following cycle.
  - '#' with count 0: ignored.
  - A-D: key_valid only; no effect on the entry.

## Timing
- Reset values: col=4'b1110, key_valid=0, key_code=0x0, entry_bcd=0x00, entry_valid=0. FSM goes to SCAN with c=0 and the divider at 0.
- Reset asserted in any state takes effect on the next edge; reset overrides everything, including an in-flight key_valid.
- key_valid and key_code update one cycle after the confirming sample.
- entry_valid and the entry_bcd update follow key_valid by one cycle.
- A key stable on column c is confirmed (DEBOUNCE_SCANS-1)*SCAN_DIV cycles after its first low sample.
- col changes only on a divider wrap, never mid-strobe.
- Divider width is clog2(SCAN_DIV). Sample counter width is clog2(DEBOUNCE_SCANS+1).

## Configuration
- KEYPAD_ENTRY_EN defined: entry register is present; entry_bcd and entry_valid operate as described.
- Undefined: entry register is removed; entry_bcd is tied to 0x00 and entry_valid to 0. Scan and key_valid behaviour is unchanged.

## Structure
- Package keypad_pkg holds:
  - key code constants (KEY_STAR=4'hE, KEY_HASH=4'hF)
  - scan state encoding (SCAN, DEBOUNCE, HOLD)
  - the 16-entry row/column-to-code map
- Sub-module keypad_entry_reg contains the BCD shift/count/commit logic. It is instantiated only under KEYPAD_ENTRY_EN.

## Test plan
Bench parameters: SCAN_DIV=4, DEBOUNCE_SCANS=3.
- Hold row1 low whenever col=4'b1101 → one key_valid, key_code=0x5, and no second pulse while held.
- row0 low for one sample on column 2, then high → no key_valid; col advances to 4'b0111.
- Press 4, 2, # with releases between → entry_valid pulse with entry_bcd=0x42; entry_bcd=0x00 next cycle.
- Press 1, 2, 3, # → entry_bcd=0x23 at the entry_valid pulse. Press 7, *, # → no entry_valid; entry_bcd=0x00.
- rows 0 and 2 low together on column 1 (keys 2 and 8) → key_code=0x2.
- Assert rst_n during HOLD with key held → next cycle col=4'b1110 and all outputs at reset values; after release of reset, the still-held key is detected exactly once.
